add_rr_arbiter: RTL

- Shares one signed adder between NUM_REQ requester channels.
- Each channel has an x input FIFO, a y input FIFO and a result output FIFO.
- A round-robin scheduler picks one eligible channel, pops one x/y pair, adds the two values and writes the sum to that channel's output FIFO.
- Sits between the per-channel stream FIFOs and the downstream consumers; also reports per-channel sticky signed-overflow flags.

---
 rtl/add_rr_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/add_rr_arbiter.sv
// add_rr_arbiter: round-robin sharing of one signed adder across NUM_REQ FIFO channels
//   clock/reset            rising-edge clock, synchronous active-low reset
//   x_in_*/y_in_*          show-ahead operand FIFOs per channel (dout, empty, rd_en)
//   out_full/wr_en/din     result FIFO per channel
//   busy/grant_id          a result is held for channel grant_id
//   ovf_flags/ovf_clr      sticky signed-overflow flags per channel, clear wins over set
module add_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_SIZE = 32,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]  x_in_dout,
  input  logic [NUM_REQ-1:0]                 x_in_empty,
  output logic [NUM_REQ-1:0]                 x_in_rd_en,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]  y_in_dout,
  input  logic [NUM_REQ-1:0]                 y_in_empty,
  output logic [NUM_REQ-1:0]                 y_in_rd_en,
  input  logic [NUM_REQ-1:0]                 out_full,
  output logic [NUM_REQ-1:0]                 out_wr_en,
  output logic [NUM_REQ-1:0][DATA_SIZE-1:0]  out_din,
  output logic                               busy,
  output logic [GW-1:0]                      grant_id,
  output logic [NUM_REQ-1:0]                 ovf_flags,
  input  logic [NUM_REQ-1:0]                 ovf_clr
);
  typedef enum logic {ARB, WRITE} state_t;
  state_t state;
  logic [GW-1:0] rr_ptr, grant, pick;
  logic [DATA_SIZE-1:0] sum, add;
  logic [NUM_REQ-1:0] elig, ovf_set;
  logic found, ovf, take, wr;
  int j;
  assign elig = ~x_in_empty & ~y_in_empty & ~out_full;
  // scan downward so the eligible channel closest above rr_ptr is the last one assigned
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (elig[j]) begin
        pick = GW'(j);
        found = 1'b1;
      end
    end
  end
  assign add = x_in_dout[pick] + y_in_dout[pick];
  assign ovf = (x_in_dout[pick][DATA_SIZE-1] == y_in_dout[pick][DATA_SIZE-1]) &&
               (add[DATA_SIZE-1] != x_in_dout[pick][DATA_SIZE-1]);
  // strobes are suppressed while reset is asserted so nothing is popped or pushed then
  assign take = reset && state == ARB && found;
  assign wr = reset && state == WRITE && !out_full[grant];
  assign ovf_set = (take && ovf) ? (NUM_REQ'(1) << pick) : '0;
  assign busy = state == WRITE;
  assign grant_id = grant;
  always_comb begin
    x_in_rd_en = '0;
    y_in_rd_en = '0;
    out_wr_en = '0;
    out_din = '0;
    x_in_rd_en[pick] = take;
    y_in_rd_en[pick] = take;
    out_wr_en[grant] = wr;
    out_din[grant] = (state == WRITE) ? sum : '0;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ARB;
      rr_ptr <= '0;
      sum <= '0;
      grant <= '0;
      ovf_flags <= '0;
    end else begin
      ovf_flags <= (ovf_flags | ovf_set) & ~ovf_clr;
      if (take) begin
        sum <= add;
        grant <= pick;
        state <= WRITE;
      end else if (wr) begin
        rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        state <= ARB;
      end
    end
  end
endmodule
